// File: rtl/seq_det_pkg.sv
// Shared types and elaboration-time helpers for the parametrised sequence detector.
// Pattern bits are ordered so that pattern[len-1] is the first bit received.
package seq_det_pkg;

    localparam int PAT_MAX = 16;

    typedef logic [PAT_MAX-1:0] pat_t;

    // Longest proper prefix of the pattern that is also a suffix of it.
    function automatic int border_len(pat_t pattern, int len);
        int  best;
        logic ok;
        best = 0;
        for (int k = 1; k < PAT_MAX; k++) begin
            if (k < len) begin
                ok = 1'b1;
                for (int i = 0; i < PAT_MAX; i++) begin
                    if (i < k && pattern[len-1-i] != pattern[k-1-i]) ok = 1'b0;
                end
                if (ok) best = k;
            end
        end
        return best;
    endfunction

    // Longest pattern prefix that is a suffix of (prefix of length s, then b), capped below len.
    function automatic int next_state(pat_t pattern, int len, int s, logic b);
        int   best;
        int   j;
        logic ok;
        logic elem;
        best = 0;
        for (int k = 1; k <= PAT_MAX; k++) begin
            if (k <= s + 1 && k < len) begin
                ok = 1'b1;
                for (int i = 0; i < PAT_MAX; i++) begin
                    if (i < k) begin
                        j    = s + 1 - k + i;
                        elem = (j == s) ? b : pattern[len-1-j];
                        if (elem != pattern[len-1-i]) ok = 1'b0;
                    end
                end
                if (ok) best = k;
            end
        end
        return best;
    endfunction

endpackage

// File: rtl/seq_sat_counter.sv
// Saturating up-counter with synchronous reset and clear; holds at all ones.
module seq_sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             sat
);

    assign sat = &count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (inc && !sat) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector: KMP-style prefix state machine with a
// combinational Mealy hit, a registered hit flag and a saturating hit counter.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int   PAT_LEN = 4,
    parameter pat_t PATTERN = 16'b1001,
    parameter bit   OVERLAP = 1'b1,
    parameter int   CNT_W   = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       x,
    input  logic                       x_valid,
    output logic                       y_mealy,
    output logic                       y_reg,
    output logic [$clog2(PAT_LEN)-1:0] state,
    output logic [CNT_W-1:0]           match_count,
    output logic                       count_sat
);

    localparam int            SW     = $clog2(PAT_LEN);
    localparam int            ROWS   = 2 ** SW;
    localparam logic [SW-1:0] LAST   = SW'(PAT_LEN - 1);
    localparam logic [SW-1:0] BORDER = SW'(border_len(PATTERN, PAT_LEN));

    if (PAT_LEN < 2 || PAT_LEN > PAT_MAX) begin : g_bad_len
        $error("seq_detector_param: PAT_LEN must be in 2..16");
    end
    if ((PATTERN >> PAT_LEN) != '0) begin : g_bad_pattern
        $error("seq_detector_param: PATTERN wider than PAT_LEN");
    end

    // Constant transition tables; rows beyond PAT_LEN-1 are unreachable padding.
    logic [ROWS-1:0][SW-1:0] ns0_table;
    logic [ROWS-1:0][SW-1:0] ns1_table;
    logic [ROWS-1:0]         exp_bit;

    for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
        if (gi < PAT_LEN) begin : g_live
            assign ns0_table[gi] = SW'(next_state(PATTERN, PAT_LEN, gi, 1'b0));
            assign ns1_table[gi] = SW'(next_state(PATTERN, PAT_LEN, gi, 1'b1));
            assign exp_bit[gi]   = PATTERN[PAT_LEN-1-gi];
        end else begin : g_pad
            assign ns0_table[gi] = '0;
            assign ns1_table[gi] = '0;
            assign exp_bit[gi]   = 1'b0;
        end
    end

    logic [SW-1:0] state_reg;
    logic [SW-1:0] state_next;
    logic          match_bit;

    assign state = state_reg;

    always_comb begin
        match_bit  = (x == exp_bit[state_reg]);
        y_mealy    = x_valid && (state_reg == LAST) && match_bit;
        state_next = state_reg;
        if (x_valid) begin
            if (y_mealy) begin
                state_next = OVERLAP ? BORDER : '0;
            end else begin
                state_next = x ? ns1_table[state_reg] : ns0_table[state_reg];
            end
        end
    end

    // y_reg is an output pipeline, so clear does not suppress a same-cycle hit.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= '0;
            y_reg     <= 1'b0;
        end else begin
            y_reg     <= y_mealy;
            state_reg <= clear ? '0 : state_next;
        end
    end

    seq_sat_counter #(
        .CNT_W(CNT_W)
    ) u_counter (
        .clk  (clk),
        .reset(reset),
        .clear(clear),
        .inc  (y_mealy),
        .count(match_count),
        .sat  (count_sat)
    );

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench for seq_detector_param: four configurations share one stimulus
// driver; each directed step queues its expected outputs for a separate monitor.
module tb_seq_detector_param;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic clear = 1'b0;
    logic x = 1'b0;
    logic x_valid = 1'b0;

    always #5 clk = ~clk;

    // dut 0: defaults
    logic       d0_mealy, d0_yreg, d0_sat;
    logic [1:0] d0_state;
    logic [7:0] d0_count;
    // dut 1: no overlap
    logic       d1_mealy, d1_yreg, d1_sat;
    logic [1:0] d1_state;
    logic [7:0] d1_count;
    // dut 2: 2-bit counter
    logic       d2_mealy, d2_yreg, d2_sat;
    logic [1:0] d2_state;
    logic [1:0] d2_count;
    // dut 3: pattern 110
    logic       d3_mealy, d3_yreg, d3_sat;
    logic [1:0] d3_state;
    logic [7:0] d3_count;

    seq_detector_param u_dut0 (
        .clk(clk), .reset(reset), .clear(clear), .x(x), .x_valid(x_valid),
        .y_mealy(d0_mealy), .y_reg(d0_yreg), .state(d0_state),
        .match_count(d0_count), .count_sat(d0_sat)
    );

    seq_detector_param #(.OVERLAP(1'b0)) u_dut1 (
        .clk(clk), .reset(reset), .clear(clear), .x(x), .x_valid(x_valid),
        .y_mealy(d1_mealy), .y_reg(d1_yreg), .state(d1_state),
        .match_count(d1_count), .count_sat(d1_sat)
    );

    seq_detector_param #(.CNT_W(2)) u_dut2 (
        .clk(clk), .reset(reset), .clear(clear), .x(x), .x_valid(x_valid),
        .y_mealy(d2_mealy), .y_reg(d2_yreg), .state(d2_state),
        .match_count(d2_count), .count_sat(d2_sat)
    );

    seq_detector_param #(.PAT_LEN(3), .PATTERN(16'b110)) u_dut3 (
        .clk(clk), .reset(reset), .clear(clear), .x(x), .x_valid(x_valid),
        .y_mealy(d3_mealy), .y_reg(d3_yreg), .state(d3_state),
        .match_count(d3_count), .count_sat(d3_sat)
    );

    typedef struct {
        int    dut;
        logic  exp_mealy;
        int    exp_state_pre;   // -1: not checked
        logic  exp_yreg;
        int    exp_state_post;
        int    exp_count;
        logic  exp_sat;
        string name;
    } txn_t;

    txn_t exp_q[$];
    int   tests_run = 0;
    int   tests_failed = 0;

    task automatic chk(string nm, string field, int act, int expv);
        tests_run++;
        if (act != expv) begin
            tests_failed++;
            $display("FAIL %s.%s: got %0d, expected %0d", nm, field, act, expv);
        end
    endtask

    function automatic int get_mealy(int d);
        case (d)
            0: return int'(d0_mealy);
            1: return int'(d1_mealy);
            2: return int'(d2_mealy);
            default: return int'(d3_mealy);
        endcase
    endfunction

    function automatic int get_state(int d);
        case (d)
            0: return int'(d0_state);
            1: return int'(d1_state);
            2: return int'(d2_state);
            default: return int'(d3_state);
        endcase
    endfunction

    function automatic int get_yreg(int d);
        case (d)
            0: return int'(d0_yreg);
            1: return int'(d1_yreg);
            2: return int'(d2_yreg);
            default: return int'(d3_yreg);
        endcase
    endfunction

    function automatic int get_count(int d);
        case (d)
            0: return int'(d0_count);
            1: return int'(d1_count);
            2: return int'(d2_count);
            default: return int'(d3_count);
        endcase
    endfunction

    function automatic int get_sat(int d);
        case (d)
            0: return int'(d0_sat);
            1: return int'(d1_sat);
            2: return int'(d2_sat);
            default: return int'(d3_sat);
        endcase
    endfunction

    // Monitor: combinational outputs mid-cycle, registered outputs just after the edge.
    initial begin : monitor
        txn_t t;
        forever begin
            @(negedge clk);
            #3;
            if (exp_q.size() > 0) begin
                t = exp_q[0];
                chk(t.name, "y_mealy", get_mealy(t.dut), int'(t.exp_mealy));
                if (t.exp_state_pre >= 0)
                    chk(t.name, "state_pre", get_state(t.dut), t.exp_state_pre);
                @(posedge clk);
                #1;
                chk(t.name, "y_reg", get_yreg(t.dut), int'(t.exp_yreg));
                chk(t.name, "state", get_state(t.dut), t.exp_state_post);
                chk(t.name, "match_count", get_count(t.dut), t.exp_count);
                chk(t.name, "count_sat", get_sat(t.dut), int'(t.exp_sat));
                $display("[TB] %s dut%0d x=%0b v=%0b state=%0d count=%0d",
                         t.name, t.dut, x, x_valid, get_state(t.dut), get_count(t.dut));
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic step(int dut, logic xi, logic vi, logic ri, logic ci,
                        logic em, int sp, logic ey, int spo, int ec, logic es, string nm);
        txn_t t;
        @(negedge clk);
        x       = xi;
        x_valid = vi;
        reset   = ri;
        clear   = ci;
        t.dut = dut; t.exp_mealy = em; t.exp_state_pre = sp; t.exp_yreg = ey;
        t.exp_state_post = spo; t.exp_count = ec; t.exp_sat = es; t.name = nm;
        exp_q.push_back(t);
    endtask

    task automatic do_reset(int dut, int sp, string nm);
        step(dut, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, sp, 1'b0, 0, 0, 1'b0, nm);
    endtask

    initial begin : driver
        int blk_bits[4] = '{1, 0, 0, 1};
        int post_s[4]   = '{1, 2, 3, 1};
        int cnt_after[5] = '{1, 2, 3, 3, 3};
        int pre_s;
        int cnt_before;
        int cnt_now;
        int wait_cycles;

        // 1: defaults, overlapping hits on 1001001
        do_reset(0, -1, "t1_rst");
        step(0, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, "t1_b1");
        step(0, 0, 1, 0, 0, 0, 1, 0, 2, 0, 0, "t1_b2");
        step(0, 0, 1, 0, 0, 0, 2, 0, 3, 0, 0, "t1_b3");
        step(0, 1, 1, 0, 0, 1, 3, 1, 1, 1, 0, "t1_b4");
        step(0, 0, 1, 0, 0, 0, 1, 0, 2, 1, 0, "t1_b5");
        step(0, 0, 1, 0, 0, 0, 2, 0, 3, 1, 0, "t1_b6");
        step(0, 1, 1, 0, 0, 1, 3, 1, 1, 2, 0, "t1_b7");
        step(0, 0, 0, 0, 0, 0, 1, 0, 1, 2, 0, "t1_idle");

        // 2: no overlap, same stream
        do_reset(1, -1, "t2_rst");
        step(1, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, "t2_b1");
        step(1, 0, 1, 0, 0, 0, 1, 0, 2, 0, 0, "t2_b2");
        step(1, 0, 1, 0, 0, 0, 2, 0, 3, 0, 0, "t2_b3");
        step(1, 1, 1, 0, 0, 1, 3, 1, 0, 1, 0, "t2_b4");
        step(1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, "t2_b5");
        step(1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, "t2_b6");
        step(1, 1, 1, 0, 0, 0, 0, 0, 1, 1, 0, "t2_b7");

        // 3: invalid cycle in the middle of a match
        do_reset(0, -1, "t3_rst");
        step(0, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, "t3_b1");
        step(0, 1, 0, 0, 0, 0, 1, 0, 1, 0, 0, "t3_gap");
        step(0, 0, 1, 0, 0, 0, 1, 0, 2, 0, 0, "t3_b2");
        step(0, 0, 1, 0, 0, 0, 2, 0, 3, 0, 0, "t3_b3");
        step(0, 1, 1, 0, 0, 1, 3, 1, 1, 1, 0, "t3_b4");

        // 4: reset mid-sequence discards the partial match
        do_reset(0, -1, "t4_rst0");
        step(0, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, "t4_b1");
        step(0, 0, 1, 0, 0, 0, 1, 0, 2, 0, 0, "t4_b2");
        step(0, 0, 1, 0, 0, 0, 2, 0, 3, 0, 0, "t4_b3");
        do_reset(0, 3, "t4_rst1");
        step(0, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, "t4_b4");

        // 5: 2-bit counter saturates, then clear (including clear on a hit)
        do_reset(2, -1, "t5_rst");
        for (int r = 0; r < 5; r++) begin
            cnt_before = (r == 0) ? 0 : cnt_after[r-1];
            for (int b = 0; b < 4; b++) begin
                pre_s   = (r == 0 || b == 0) ? ((r == 0) ? b : 1) : b;
                cnt_now = (b == 3) ? cnt_after[r] : cnt_before;
                step(2, blk_bits[b][0], 1, 0, 0, (b == 3), pre_s, (b == 3),
                     post_s[b], cnt_now, (cnt_now == 3), $sformatf("t5_r%0d_b%0d", r, b));
            end
        end
        step(2, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, "t5_clear");
        step(2, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, "t5_c1");
        step(2, 0, 1, 0, 0, 0, 1, 0, 2, 0, 0, "t5_c2");
        step(2, 0, 1, 0, 0, 0, 2, 0, 3, 0, 0, "t5_c3");
        step(2, 1, 1, 0, 1, 1, 3, 1, 0, 0, 0, "t5_clear_hit");
        step(2, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, "t5_after");

        // 6: PAT_LEN=3, pattern 110, stream 1110
        do_reset(3, -1, "t6_rst");
        step(3, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, "t6_b1");
        step(3, 1, 1, 0, 0, 0, 1, 0, 2, 0, 0, "t6_b2");
        step(3, 1, 1, 0, 0, 0, 2, 0, 2, 0, 0, "t6_b3");
        step(3, 0, 1, 0, 0, 1, 2, 1, 0, 1, 0, "t6_b4");
        step(3, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, "t6_idle");

        @(negedge clk);
        x_valid = 1'b0;
        clear   = 1'b0;
        reset   = 1'b0;
        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 20) begin
            @(negedge clk);
            wait_cycles++;
        end
        if (exp_q.size() > 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
        end
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
